// File: rtl/reg_file_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// FSM encodings, requester IDs and default widths.
package reg_file_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. req_i[0] is requester A, req_i[1] is B;
// pointer_i names the requester that wins a tie.
module rr_arb2
  import reg_file_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       pointer_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    unique case (req_i)
      2'b01:   grant_id_o = REQ_A;
      2'b10:   grant_id_o = REQ_B;
      default: grant_id_o = pointer_i;
    endcase
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port register file between
// requesters A and B; serialises accesses and routes read data back to the issuer.
module reg_file_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_Req,
  input  logic                  A_WrEn,
  input  logic [ADDR_WIDTH-1:0] A_Addr,
  input  logic [DATA_WIDTH-1:0] A_WrData,
  output logic                  A_Gnt,
  output logic                  A_RdValid,
  output logic [DATA_WIDTH-1:0] A_RdData,
  input  logic                  B_Req,
  input  logic                  B_WrEn,
  input  logic [ADDR_WIDTH-1:0] B_Addr,
  input  logic [DATA_WIDTH-1:0] B_WrData,
  output logic                  B_Gnt,
  output logic                  B_RdValid,
  output logic [DATA_WIDTH-1:0] B_RdData,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  output logic                  Busy
);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  a_gnt_q, a_gnt_d;
  logic                  b_gnt_q, b_gnt_d;
  logic                  a_rd_valid_q, a_rd_valid_d;
  logic                  b_rd_valid_q, b_rd_valid_d;
  logic [DATA_WIDTH-1:0] a_rd_data_q, a_rd_data_d;
  logic [DATA_WIDTH-1:0] b_rd_data_q, b_rd_data_d;

  logic grant_valid;
  logic grant_id;

  rr_arb2 u_rr_arb2 (
    .req_i         ({B_Req, A_Req}),
    .pointer_i     (ptr_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rd_valid_d = 1'b0;
    b_rd_valid_d = 1'b0;
    a_rd_data_d  = a_rd_data_q;
    b_rd_data_d  = b_rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
          owner_d = grant_id;
          // Pointer always moves to the side that did not win, even if it was idle.
          ptr_d   = ~grant_id;
          if (grant_id == REQ_B) begin
            rf_addr_d  = B_Addr;
            rf_wdata_d = B_WrData;
            rf_wr_en_d = B_WrEn;
            rf_rd_en_d = ~B_WrEn;
            b_gnt_d    = 1'b1;
          end else begin
            rf_addr_d  = A_Addr;
            rf_wdata_d = A_WrData;
            rf_wr_en_d = A_WrEn;
            rf_rd_en_d = ~A_WrEn;
            a_gnt_d    = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_d = rf_wr_en_q ? IDLE : RDCAP;
      end
      RDCAP: begin
        state_d = IDLE;
        if (owner_q == REQ_B) begin
          b_rd_data_d  = RF_RdData;
          b_rd_valid_d = 1'b1;
        end else begin
          a_rd_data_d  = RF_RdData;
          a_rd_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      ptr_q        <= REQ_A;
      owner_q      <= REQ_A;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rd_valid_q <= 1'b0;
      b_rd_valid_q <= 1'b0;
      a_rd_data_q  <= '0;
      b_rd_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rd_valid_q <= a_rd_valid_d;
      b_rd_valid_q <= b_rd_valid_d;
      a_rd_data_q  <= a_rd_data_d;
      b_rd_data_q  <= b_rd_data_d;
    end
  end

  assign A_Gnt      = a_gnt_q;
  assign B_Gnt      = b_gnt_q;
  assign A_RdValid  = a_rd_valid_q;
  assign B_RdValid  = b_rd_valid_q;
  assign A_RdData   = a_rd_data_q;
  assign B_RdData   = b_rd_data_q;
  assign RF_WrEn    = rf_wr_en_q;
  assign RF_RdEn    = rf_rd_en_q;
  assign RF_Address = rf_addr_q;
  assign RF_WrData  = rf_wdata_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed and randomised bench for reg_file_arbiter with a behavioural
// single-port register file (1-cycle registered read).
module tb_reg_file_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        A_Req = 1'b0, A_WrEn = 1'b0;
  logic [2:0]  A_Addr = '0;
  logic [15:0] A_WrData = '0;
  logic        B_Req = 1'b0, B_WrEn = 1'b0;
  logic [2:0]  B_Addr = '0;
  logic [15:0] B_WrData = '0;
  logic        A_Gnt, A_RdValid, B_Gnt, B_RdValid;
  logic [15:0] A_RdData, B_RdData;
  logic        RF_WrEn, RF_RdEn, Busy;
  logic [2:0]  RF_Address;
  logic [15:0] RF_WrData, RF_RdData;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  reg_file_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A_Req      (A_Req),
    .A_WrEn     (A_WrEn),
    .A_Addr     (A_Addr),
    .A_WrData   (A_WrData),
    .A_Gnt      (A_Gnt),
    .A_RdValid  (A_RdValid),
    .A_RdData   (A_RdData),
    .B_Req      (B_Req),
    .B_WrEn     (B_WrEn),
    .B_Addr     (B_Addr),
    .B_WrData   (B_WrData),
    .B_Gnt      (B_Gnt),
    .B_RdValid  (B_RdValid),
    .B_RdData   (B_RdData),
    .RF_WrEn    (RF_WrEn),
    .RF_RdEn    (RF_RdEn),
    .RF_Address (RF_Address),
    .RF_WrData  (RF_WrData),
    .RF_RdData  (RF_RdData),
    .Busy       (Busy)
  );

  // Register file model: write commits at the edge, read data registered.
  logic [15:0] rf_mem [8];
  logic [15:0] rf_rd_q;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_rd_q <= '0;
    end else begin
      if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
      if (RF_RdEn) rf_rd_q <= rf_mem[RF_Address];
    end
  end
  assign RF_RdData = rf_rd_q;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_a(input logic req, input logic wr, input logic [2:0] addr,
                       input logic [15:0] data);
    A_Req = req; A_WrEn = wr; A_Addr = addr; A_WrData = data;
  endtask

  task automatic set_b(input logic req, input logic wr, input logic [2:0] addr,
                       input logic [15:0] data);
    B_Req = req; B_WrEn = wr; B_Addr = addr; B_WrData = data;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({A_Gnt, B_Gnt, A_RdValid, B_RdValid, RF_WrEn, RF_RdEn, Busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {A_Gnt, B_Gnt, A_RdValid, B_RdValid, RF_WrEn, RF_RdEn, Busy});
    end
    checks++;
    if ({RF_Address, RF_WrData, A_RdData, B_RdData} !== 51'd0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h ard=%h brd=%h expected all 0",
               RF_Address, RF_WrData, A_RdData, B_RdData);
    end
    #3 RST = 1'b1;
    tick;
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b expected 0", Busy);
    end
  endtask

  task automatic test_simultaneous;
    set_a(1, 1, 3'd1, 16'h1111);
    set_b(1, 1, 3'd2, 16'h2222);
    tick;
    checks++;
    if ({A_Gnt, B_Gnt, RF_WrEn, RF_RdEn, Busy} !== 5'b10101) begin
      failures++;
      $display("FAIL sim1_ctrl: got %b expected 10101", {A_Gnt, B_Gnt, RF_WrEn, RF_RdEn, Busy});
    end
    checks++;
    if (RF_Address !== 3'd1 || RF_WrData !== 16'h1111) begin
      failures++;
      $display("FAIL sim1_payload: got %h/%h expected 1/1111", RF_Address, RF_WrData);
    end
    set_a(0, 0, 0, 0);
    tick;
    checks++;
    if ({B_Gnt, Busy} !== 2'b00) begin
      failures++;
      $display("FAIL sim1_idle: got gnt/busy %b expected 00", {B_Gnt, Busy});
    end
    tick;
    checks++;
    if ({A_Gnt, B_Gnt} !== 2'b01 || RF_Address !== 3'd2 || RF_WrData !== 16'h2222) begin
      failures++;
      $display("FAIL sim1_b_grant: got gnt=%b addr=%h data=%h expected 01/2/2222",
               {A_Gnt, B_Gnt}, RF_Address, RF_WrData);
    end
    set_b(0, 0, 0, 0);
    tick;
    // A alone moves the pointer to B, so the next tie goes to B.
    set_a(1, 1, 3'd0, 16'h0A0A);
    tick;
    checks++;
    if (A_Gnt !== 1'b1) begin
      failures++;
      $display("FAIL sim_a_alone: got %b expected 1", A_Gnt);
    end
    set_a(0, 0, 0, 0);
    tick;
    set_a(1, 1, 3'd5, 16'h5555);
    set_b(1, 1, 3'd4, 16'h4444);
    tick;
    checks++;
    if ({A_Gnt, B_Gnt} !== 2'b01 || RF_Address !== 3'd4) begin
      failures++;
      $display("FAIL sim2_b_first: got gnt=%b addr=%h expected 01/4", {A_Gnt, B_Gnt}, RF_Address);
    end
    set_b(0, 0, 0, 0);
    tick;
    tick;
    checks++;
    if ({A_Gnt, B_Gnt} !== 2'b10 || RF_Address !== 3'd5) begin
      failures++;
      $display("FAIL sim2_a_next: got gnt=%b addr=%h expected 10/5", {A_Gnt, B_Gnt}, RF_Address);
    end
    set_a(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_write_read;
    set_a(1, 1, 3'd3, 16'hBEEF);
    tick;
    checks++;
    if ({A_Gnt, RF_WrEn, RF_RdEn} !== 3'b110 || RF_Address !== 3'd3 || RF_WrData !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_issue: got %b addr=%h data=%h expected 110/3/beef",
               {A_Gnt, RF_WrEn, RF_RdEn}, RF_Address, RF_WrData);
    end
    set_a(1, 0, 3'd3, 16'h0);
    tick;
    checks++;
    if ({A_Gnt, RF_WrEn, Busy} !== 3'b000) begin
      failures++;
      $display("FAIL wr_done: got %b expected 000", {A_Gnt, RF_WrEn, Busy});
    end
    tick;
    checks++;
    if ({A_Gnt, RF_WrEn, RF_RdEn} !== 3'b101 || RF_Address !== 3'd3) begin
      failures++;
      $display("FAIL rd_issue: got %b addr=%h expected 101/3", {A_Gnt, RF_WrEn, RF_RdEn}, RF_Address);
    end
    set_a(0, 0, 0, 0);
    tick;
    checks++;
    if ({Busy, A_RdValid, RF_RdEn} !== 3'b100) begin
      failures++;
      $display("FAIL rd_cap: got busy/valid/rden %b expected 100", {Busy, A_RdValid, RF_RdEn});
    end
    tick;
    checks++;
    if (A_RdValid !== 1'b1 || A_RdData !== 16'hBEEF || Busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_return: got valid=%b data=%h busy=%b expected 1/beef/0",
               A_RdValid, A_RdData, Busy);
    end
    tick;
    checks++;
    if (A_RdValid !== 1'b0 || A_RdData !== 16'hBEEF) begin
      failures++;
      $display("FAIL rd_hold: got valid=%b data=%h expected 0/beef", A_RdValid, A_RdData);
    end
  endtask

  task automatic test_read_isolation;
    set_a(1, 0, 3'd1, 16'h0);
    set_b(1, 0, 3'd2, 16'h0);
    tick;
    checks++;
    if ({A_Gnt, B_Gnt, RF_RdEn} !== 3'b011) begin
      failures++;
      $display("FAIL iso_b_grant: got %b expected 011", {A_Gnt, B_Gnt, RF_RdEn});
    end
    set_b(0, 0, 0, 0);
    tick;
    tick;
    checks++;
    if (B_RdValid !== 1'b1 || B_RdData !== 16'h2222 || A_RdValid !== 1'b0 ||
        A_RdData !== 16'hBEEF) begin
      failures++;
      $display("FAIL iso_b_data: got bv=%b bd=%h av=%b ad=%h expected 1/2222/0/beef",
               B_RdValid, B_RdData, A_RdValid, A_RdData);
    end
    tick;
    checks++;
    if (A_Gnt !== 1'b1 || RF_Address !== 3'd1) begin
      failures++;
      $display("FAIL iso_a_grant: got gnt=%b addr=%h expected 1/1", A_Gnt, RF_Address);
    end
    set_a(0, 0, 0, 0);
    tick;
    tick;
    checks++;
    if (A_RdValid !== 1'b1 || A_RdData !== 16'h1111 || B_RdValid !== 1'b0 ||
        B_RdData !== 16'h2222) begin
      failures++;
      $display("FAIL iso_a_data: got av=%b ad=%h bv=%b bd=%h expected 1/1111/0/2222",
               A_RdValid, A_RdData, B_RdValid, B_RdData);
    end
  endtask

  task automatic test_busy_request;
    set_a(1, 0, 3'd4, 16'h0);
    tick;
    checks++;
    if (A_Gnt !== 1'b1) begin
      failures++;
      $display("FAIL busy_a_grant: got %b expected 1", A_Gnt);
    end
    set_a(0, 0, 0, 0);
    set_b(1, 0, 3'd5, 16'h0);
    tick;
    checks++;
    if (B_Gnt !== 1'b0) begin
      failures++;
      $display("FAIL busy_b_in_rdcap: got %b expected 0", B_Gnt);
    end
    tick;
    checks++;
    if (A_RdValid !== 1'b1 || A_RdData !== 16'h4444 || B_Gnt !== 1'b0) begin
      failures++;
      $display("FAIL busy_a_return: got av=%b ad=%h bg=%b expected 1/4444/0",
               A_RdValid, A_RdData, B_Gnt);
    end
    tick;
    checks++;
    if (B_Gnt !== 1'b1 || RF_RdEn !== 1'b1 || RF_Address !== 3'd5) begin
      failures++;
      $display("FAIL busy_b_grant: got gnt=%b rden=%b addr=%h expected 1/1/5",
               B_Gnt, RF_RdEn, RF_Address);
    end
    set_b(0, 0, 0, 0);
    tick;
    tick;
    checks++;
    if (B_RdValid !== 1'b1 || B_RdData !== 16'h5555) begin
      failures++;
      $display("FAIL busy_b_return: got bv=%b bd=%h expected 1/5555", B_RdValid, B_RdData);
    end
  endtask

  task automatic test_reset_mid_read;
    bit saw_valid;
    set_a(1, 0, 3'd3, 16'h0);
    tick;
    set_a(0, 0, 0, 0);
    tick;
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_in_rdcap: got busy=%b expected 1", Busy);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({A_Gnt, B_Gnt, A_RdValid, B_RdValid, RF_WrEn, RF_RdEn, Busy} !== 7'b0 ||
        {RF_Address, RF_WrData, A_RdData, B_RdData} !== 51'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: ctrl=%b addr=%h wd=%h ard=%h brd=%h expected all 0",
               {A_Gnt, B_Gnt, A_RdValid, B_RdValid, RF_WrEn, RF_RdEn, Busy},
               RF_Address, RF_WrData, A_RdData, B_RdData);
    end
    @(posedge CLK);
    #3 RST = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      tick;
      if (A_RdValid !== 1'b0 || Busy !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL rst_mid_no_valid: got activity=1 expected 0");
    end
    // Pointer was at B before reset; after reset a tie must go to A.
    set_a(1, 1, 3'd6, 16'h6666);
    set_b(1, 1, 3'd7, 16'h7777);
    tick;
    checks++;
    if ({A_Gnt, B_Gnt} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_ptr: got gnt=%b expected 10", {A_Gnt, B_Gnt});
    end
    set_a(0, 0, 0, 0);
    tick;
    tick;
    set_b(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_random;
    logic [15:0] sb [8];
    logic [15:0] a_exp, b_exp;
    logic        a_exp_v, b_exp_v;
    int          a_wait, b_wait;
    for (int i = 0; i < 8; i++) sb[i] = rf_mem[i];
    a_exp = '0; b_exp = '0; a_exp_v = 1'b0; b_exp_v = 1'b0; a_wait = 0; b_wait = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++;
      if ((RF_WrEn & RF_RdEn) !== 1'b0) begin
        failures++;
        $display("FAIL rand_excl_en: cyc %0d got wr&rd=1 expected 0", cyc);
      end
      checks++;
      if ((A_Gnt & B_Gnt) !== 1'b0) begin
        failures++;
        $display("FAIL rand_excl_gnt: cyc %0d got both gnt expected one", cyc);
      end
      if (A_RdValid) begin
        checks++;
        if (!a_exp_v || A_RdData !== a_exp) begin
          failures++;
          $display("FAIL rand_a_rd: cyc %0d got %h expected %h (pending=%b)",
                   cyc, A_RdData, a_exp, a_exp_v);
        end
        a_exp_v = 1'b0;
      end
      if (B_RdValid) begin
        checks++;
        if (!b_exp_v || B_RdData !== b_exp) begin
          failures++;
          $display("FAIL rand_b_rd: cyc %0d got %h expected %h (pending=%b)",
                   cyc, B_RdData, b_exp, b_exp_v);
        end
        b_exp_v = 1'b0;
      end
      if (A_Gnt) begin
        checks++;
        if (!A_Req || RF_Address !== A_Addr || RF_WrEn !== A_WrEn ||
            (A_WrEn && RF_WrData !== A_WrData)) begin
          failures++;
          $display("FAIL rand_a_issue: cyc %0d got req=%b addr=%h we=%b wd=%h expected %h/%b/%h",
                   cyc, A_Req, RF_Address, RF_WrEn, RF_WrData, A_Addr, A_WrEn, A_WrData);
        end
        if (A_WrEn) sb[A_Addr] = A_WrData;
        else begin a_exp = sb[A_Addr]; a_exp_v = 1'b1; end
      end
      if (B_Gnt) begin
        checks++;
        if (!B_Req || RF_Address !== B_Addr || RF_WrEn !== B_WrEn ||
            (B_WrEn && RF_WrData !== B_WrData)) begin
          failures++;
          $display("FAIL rand_b_issue: cyc %0d got req=%b addr=%h we=%b wd=%h expected %h/%b/%h",
                   cyc, B_Req, RF_Address, RF_WrEn, RF_WrData, B_Addr, B_WrEn, B_WrData);
        end
        if (B_WrEn) sb[B_Addr] = B_WrData;
        else begin b_exp = sb[B_Addr]; b_exp_v = 1'b1; end
      end
      a_wait = (A_Req && !A_Gnt) ? a_wait + 1 : 0;
      b_wait = (B_Req && !B_Gnt) ? b_wait + 1 : 0;
      checks++;
      if (a_wait > 10 || b_wait > 10) begin
        failures++;
        $display("FAIL rand_starve: cyc %0d got waits %0d/%0d expected <=10", cyc, a_wait, b_wait);
        a_wait = 0;
        b_wait = 0;
      end
      if (!A_Req || A_Gnt) begin
        if (cyc < 9980 && $urandom_range(0, 2) != 0)
          set_a(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        else set_a(0, 0, 0, 0);
      end
      if (!B_Req || B_Gnt) begin
        if (cyc < 9980 && $urandom_range(0, 2) != 0)
          set_b(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        else set_b(0, 0, 0, 0);
      end
      tick;
    end
    checks++;
    if (a_exp_v || b_exp_v || A_Req || B_Req || Busy) begin
      failures++;
      $display("FAIL rand_drain: got pend=%b%b req=%b%b busy=%b expected all 0",
               a_exp_v, b_exp_v, A_Req, B_Req, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_write_read();
    test_read_isolation();
    test_busy_request();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
